// File: rtl/imm_gen.sv
// imm_gen: registered RV32I immediate decoder, ImmSel picks the instruction format
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears operand
//   ImmSel     in   3-bit format select (I,S,B,U,J,shamt,zimm,reserved)
//   instr_addr in   32-bit instruction word
//   operand    out  32-bit decoded immediate, one cycle after the inputs
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      ImmSel,
    input  logic [XLEN-1:0] instr_addr,
    output logic [XLEN-1:0] operand
);
    logic [XLEN-1:0] imm;
    logic            s;

    assign s = instr_addr[31];

    // the default arm also catches an unknown select, giving zero
    always_comb begin
        imm = '0;
        case (ImmSel)
            3'd0:    imm = {{20{s}}, instr_addr[31:20]};
            3'd1:    imm = {{20{s}}, instr_addr[31:25], instr_addr[11:7]};
            3'd2:    imm = {{19{s}}, s, instr_addr[7], instr_addr[30:25], instr_addr[11:8], 1'b0};
            3'd3:    imm = {instr_addr[31:12], 12'h000};
            3'd4:    imm = {{11{s}}, s, instr_addr[19:12], instr_addr[20], instr_addr[30:21], 1'b0};
            3'd5:    imm = {27'b0, instr_addr[24:20]};
            3'd6:    imm = {27'b0, instr_addr[19:15]};
            default: imm = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) operand <= '0;
        else        operand <= imm;
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed vector table plus reset/hold sequences for imm_gen
module tb_imm_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] instr = 32'h0;
    logic [31:0] operand;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] i;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[30];

    imm_gen dut (
        .clk(clk),
        .rst_n(rst_n),
        .ImmSel(sel),
        .instr_addr(instr),
        .operand(operand)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] s, input logic [31:0] i);
        @(negedge clk);
        sel = s;
        instr = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h952F0F3A, 32'hFFFFF952};
        vecs[1]  = '{3'd0, 32'h7FF00000, 32'h000007FF};
        vecs[2]  = '{3'd0, 32'h80000000, 32'hFFFFF800};
        vecs[3]  = '{3'd1, 32'hB72F89BA, 32'hFFFFFB73};
        vecs[4]  = '{3'd1, 32'h00000F80, 32'h0000001F};
        vecs[5]  = '{3'd1, 32'hFE000000, 32'hFFFFFFE0};
        vecs[6]  = '{3'd2, 32'h952F8F3A, 32'hFFFFF15E};
        vecs[7]  = '{3'd2, 32'h00000080, 32'h00000800};
        vecs[8]  = '{3'd2, 32'h00000F00, 32'h0000001E};
        vecs[9]  = '{3'd2, 32'h7E000000, 32'h000007E0};
        vecs[10] = '{3'd3, 32'hD52F053A, 32'hD52F0000};
        vecs[11] = '{3'd3, 32'h00000FFF, 32'h00000000};
        vecs[12] = '{3'd4, 32'h952F173A, 32'hFFFF1152};
        vecs[13] = '{3'd4, 32'h00100000, 32'h00000800};
        vecs[14] = '{3'd4, 32'h7FE00000, 32'h000007FE};
        vecs[15] = '{3'd4, 32'h000FF000, 32'h000FF000};
        vecs[16] = '{3'd4, 32'h80000000, 32'hFFF00000};
        vecs[17] = '{3'd5, 32'h152F0F3A, 32'h00000012};
        vecs[18] = '{3'd5, 32'h01F00000, 32'h0000001F};
        vecs[19] = '{3'd5, 32'hFE0FFFFF, 32'h00000000};
        vecs[20] = '{3'd6, 32'h952F0F3A, 32'h0000001E};
        vecs[21] = '{3'd6, 32'h000F8000, 32'h0000001F};
        vecs[22] = '{3'd6, 32'hFFF07FFF, 32'h00000000};
        vecs[23] = '{3'd7, 32'hFFFFFFFF, 32'h00000000};
        vecs[24] = '{3'd7, 32'h952F0F3A, 32'h00000000};
        vecs[25] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[26] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[27] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[28] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFF000};
        vecs[29] = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFE};

        // held in reset across edges with decodable inputs
        sel = 3'd0;
        instr = 32'h952F0F3A;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", operand, 32'h0);

        // release: first edge loads the decode
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_load", operand, 32'hFFFFF952);

        for (int k = 0; k < 30; k++) begin
            apply(vecs[k].sel, vecs[k].i);
            check($sformatf("vec%0d_sel%0d", k, vecs[k].sel), operand, vecs[k].exp);
        end

        // inputs changed between edges must not reach operand early
        apply(3'd3, 32'hD52F053A);
        check("hold_a", operand, 32'hD52F0000);
        sel = 3'd0;
        instr = 32'h952F0F3A;
        #3;
        check("hold_between_edges", operand, 32'hD52F0000);
        @(posedge clk);
        #1;
        check("hold_next_edge", operand, 32'hFFFFF952);

        // asynchronous reset mid-cycle clears with no clock edge
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", operand, 32'h0);
        sel = 3'd4;
        instr = 32'h952F173A;
        @(posedge clk);
        #1;
        check("reset_held_edge", operand, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", operand, 32'h0);
        @(posedge clk);
        #1;
        check("release_reload", operand, 32'hFFFF1152);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
